// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : 16-bit execute-stage ALU for the pipelined MIPS datapath.
//                Eight operations selected by aluCnt; result and zero flag are
//                registered at the stage boundary (1-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [2:0]  aluCnt,
    output logic [15:0] aluResult,
    output logic        zero
);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_NOT = 3'd2;
    localparam logic [2:0] c_OP_SL  = 3'd3;
    localparam logic [2:0] c_OP_SR  = 3'd4;
    localparam logic [2:0] c_OP_AND = 3'd5;
    localparam logic [2:0] c_OP_OR  = 3'd6;
    localparam logic [2:0] c_OP_SLT = 3'd7;

    logic [15:0] w_result;
    logic        w_shift_oor;
    logic [15:0] w_shl;
    logic [15:0] w_shr;
    logic        w_lt_signed;
    logic [15:0] r_result;
    logic        r_zero;

    // Any shift amount of 16 or more clears every bit, so only the low nibble
    // drives the shifter and the upper bits force a zero result.
    assign w_shift_oor = |in2[15:4];
    assign w_shl       = w_shift_oor ? 16'h0000 : (in1 << in2[3:0]);
    assign w_shr       = w_shift_oor ? 16'h0000 : (in1 >> in2[3:0]);
    assign w_lt_signed = ($signed(in1) < $signed(in2));

    always_comb begin
        w_result = 16'h0000;
        case (aluCnt)
            c_OP_ADD: w_result = in1 + in2;
            c_OP_SUB: w_result = in1 - in2;
            c_OP_NOT: w_result = ~in1;
            c_OP_SL:  w_result = w_shl;
            c_OP_SR:  w_result = w_shr;
            c_OP_AND: w_result = in1 & in2;
            c_OP_OR:  w_result = in1 | in2;
            c_OP_SLT: w_result = {15'd0, w_lt_signed};
            default:  w_result = 16'h0000;
        endcase
    end

    // Zero is computed from the same next value so both outputs stay coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 16'h0000;
            r_zero   <= 1'b1;
        end else begin
            r_result <= w_result;
            r_zero   <= (w_result == 16'h0000);
        end
    end

    assign aluResult = r_result;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu
//  Description : Self-checking bench for alu: directed cases plus randomized
//                operations against a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    logic        clk;
    logic        rst;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [2:0]  aluCnt;
    logic [15:0] aluResult;
    logic        zero;

    int n_cmp;
    int n_err;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .aluCnt    (aluCnt),
        .aluResult (aluResult),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written from the operation definitions with integer math.
    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
        int ia, ib, sa, sb, r;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 32768) ? ia - 65536 : ia;
        sb = (ib >= 32768) ? ib - 65536 : ib;
        case (op)
            3'd0: r = (ia + ib) % 65536;
            3'd1: r = (ia - ib + 65536) % 65536;
            3'd2: r = 65535 - ia;
            3'd3: r = (ib >= 16) ? 0 : (ia * (1 << ib)) % 65536;
            3'd4: r = (ib >= 16) ? 0 : ia / (1 << ib);
            3'd5: r = int'(a & b);
            3'd6: r = int'(a | b);
            default: r = (sa < sb) ? 1 : 0;
        endcase
        return r[15:0];
    endfunction

    // Drive inputs away from the active edge, clock once, sample 1 time unit later.
    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        @(negedge clk);
        in1    = a;
        in2    = b;
        aluCnt = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        step(16'd5, 16'd2, 3'd0);
        n_cmp++;
        if (aluResult !== 16'h0000 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL reset: got result=%h zero=%b, expected result=0000 zero=1", aluResult, zero);
        end
        rst = 1'b0;
        step(16'd5, 16'd2, 3'd0);
        n_cmp++;
        if (aluResult !== 16'd7 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got result=%h zero=%b, expected result=0007 zero=0", aluResult, zero);
        end
        // Reset in the middle of live traffic must override the pending operation.
        rst = 1'b1;
        step(16'h1234, 16'h0001, 3'd0);
        n_cmp++;
        if (aluResult !== 16'h0000 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL reset_priority: got result=%h zero=%b, expected result=0000 zero=1", aluResult, zero);
        end
        rst = 1'b0;
    endtask

    task automatic run_table(input string name, input logic [15:0] ta[], input logic [15:0] tb[],
                             input logic [2:0] top[], input logic [15:0] texp[]);
        for (int i = 0; i < ta.size(); i++) begin
            step(ta[i], tb[i], top[i]);
            n_cmp++;
            if (aluResult !== texp[i] || zero !== (texp[i] == 16'h0000)) begin
                n_err++;
                $display("FAIL %s[%0d]: op=%0d a=%h b=%h got result=%h zero=%b, expected result=%h zero=%b",
                         name, i, top[i], ta[i], tb[i], aluResult, zero, texp[i], (texp[i] == 16'h0000));
            end
        end
    endtask

    task automatic test_arith;
        run_table("arith",
                  '{16'd1, 16'd5, 16'hFFFF, 16'd0},
                  '{16'd0, 16'd2, 16'd1,    16'd1},
                  '{3'd0,  3'd1,  3'd0,     3'd1},
                  '{16'd1, 16'd3, 16'd0,    16'hFFFF});
    endtask

    task automatic test_logic;
        run_table("logic",
                  '{16'd5,    16'd5, 16'd5},
                  '{16'd2,    16'd2, 16'd2},
                  '{3'd2,     3'd5,  3'd6},
                  '{16'hFFFA, 16'd0, 16'd7});
    endtask

    task automatic test_shift;
        run_table("shift",
                  '{16'd5,  16'd5, 16'h8000, 16'd5,  16'hFFFF, 16'h0001, 16'hFFFF},
                  '{16'd2,  16'd2, 16'd15,   16'd16, 16'd16,   16'd15,   16'h0100},
                  '{3'd3,   3'd4,  3'd4,     3'd3,   3'd4,     3'd3,     3'd3},
                  '{16'd20, 16'd1, 16'd1,    16'd0,  16'd0,    16'h8000, 16'd0});
    endtask

    task automatic test_slt;
        run_table("slt",
                  '{16'd5, 16'd2, 16'hFFFF, 16'h7FFF, 16'h8000},
                  '{16'd2, 16'd5, 16'd1,    16'h8000, 16'h7FFF},
                  '{3'd7,  3'd7,  3'd7,     3'd7,     3'd7},
                  '{16'd0, 16'd1, 16'd1,    16'd0,    16'd1});
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_seq [8];
        exp_seq = '{16'd7, 16'd3, 16'hFFFA, 16'd20, 16'd1, 16'd0, 16'd7, 16'd0};
        for (int i = 0; i < 8; i++) begin
            step(16'd5, 16'd2, 3'(i));
            n_cmp++;
            if (aluResult !== exp_seq[i] || zero !== (exp_seq[i] == 16'h0000)) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got result=%h zero=%b, expected result=%h zero=%b",
                         i, aluResult, zero, exp_seq[i], (exp_seq[i] == 16'h0000));
            end
        end
    endtask

    task automatic test_hold;
        step(16'd100, 16'd23, 3'd0);
        in1    = 16'h0000;
        in2    = 16'h0000;
        aluCnt = 3'd5;
        #2;
        n_cmp++;
        if (aluResult !== 16'd123 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL hold: got result=%h zero=%b, expected result=007b zero=0", aluResult, zero);
        end
        step(16'h0000, 16'h0000, 3'd5);
        n_cmp++;
        if (aluResult !== 16'h0000 || zero !== 1'b1) begin
            n_err++;
            $display("FAIL hold_next: got result=%h zero=%b, expected result=0000 zero=1", aluResult, zero);
        end
    endtask

    task automatic test_random;
        logic [15:0] a, b, e;
        logic [2:0]  op;
        for (int i = 0; i < 400; i++) begin
            a  = 16'($urandom);
            op = 3'($urandom_range(0, 7));
            if (op == 3'd3 || op == 3'd4)
                b = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
            else if ($urandom_range(0, 7) == 0)
                b = a;
            else
                b = 16'($urandom);
            e = ref_alu(a, b, op);
            step(a, b, op);
            n_cmp++;
            if (aluResult !== e || zero !== (e == 16'h0000)) begin
                n_err++;
                $display("FAIL random[%0d]: op=%0d a=%h b=%h got result=%h zero=%b, expected result=%h zero=%b",
                         i, op, a, b, aluResult, zero, e, (e == 16'h0000));
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b0;
        in1    = 16'h0000;
        in2    = 16'h0000;
        aluCnt = 3'd0;
        test_reset;
        test_arith;
        test_logic;
        test_shift;
        test_slt;
        test_back_to_back;
        test_hold;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
